// File: rtl/aud_lr_recorder.sv
// ============================================================================
// Module  : aud_lr_recorder
// Brief   : I2S ADC capture from the WM8731 into 16-bit samples with SRAM
//           write strobe and address. Optional stereo capture under the
//           AUD_REC_STEREO_EN macro (default build: mono, left channel only).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aud_lr_recorder #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrc,
    input  logic              i_data,
    output logic [ADDR_W-1:0] o_address,
    output logic [15:0]       o_data,
    output logic              o_wr_en,
    output logic              o_busy,
    output logic              o_finished,
    output logic [2:0]        o_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_PAUSED = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_lrc_q;
    logic [3:0]        r_bit_cnt;
    logic [15:0]       r_shift;
    logic [15:0]       r_data;
    logic [ADDR_W-1:0] r_address;
    logic              r_finished;
    logic              w_wr_en;
    logic              w_busy;
    logic              w_fall;
    logic              w_edge;
    logic              w_pause_ok;

    assign w_fall = r_lrc_q & ~i_lrc;

`ifdef AUD_REC_STEREO_EN
    logic r_right;
    logic w_rise;

    // r_right set means the left sample has been written and the right one is due
    assign w_rise     = ~r_lrc_q & i_lrc;
    assign w_edge     = r_right ? w_rise : w_fall;
    assign w_pause_ok = ~r_right;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_right <= 1'b0;
        end else if (r_state == S_IDLE && w_next == S_WAIT) begin
            r_right <= 1'b0;
        end else if (r_state == S_WRITE) begin
            r_right <= ~r_right;
        end
    end
`else
    assign w_edge     = w_fall;
    assign w_pause_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && i_init_done) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                end else if (w_pause_ok && i_pause) begin
                    w_next = S_PAUSED;
                end else if (w_edge) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                end else if (r_bit_cnt == 4'd15) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_stop || r_address == ADDR_MAX) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_PAUSED: begin
                if (i_stop) begin
                    w_next = S_IDLE;
                end else if (!i_pause) begin
                    w_next = S_WAIT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en = (r_state == S_WRITE);
        w_busy  = (r_state != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lrc_q    <= 1'b1;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 16'd0;
            r_data     <= 16'd0;
            r_address  <= '0;
            r_finished <= 1'b0;
        end else begin
            r_lrc_q    <= i_lrc;
            r_finished <= (r_state != S_IDLE) && (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_WAIT) begin
                        r_address <= '0;
                    end
                end
                S_WAIT: begin
                    // the bit under the LRC edge is the I2S delay slot
                    if (w_next == S_SHIFT) begin
                        r_bit_cnt <= 4'd0;
                    end
                end
                S_SHIFT: begin
                    r_shift <= {r_shift[14:0], i_data};
                    if (r_bit_cnt != 4'd15) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    if (w_next == S_WRITE) begin
                        r_data <= {r_shift[14:0], i_data};
                    end
                end
                S_WRITE: begin
                    if (w_next == S_WAIT) begin
                        r_address <= r_address + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_address  = r_address;
    assign o_data     = r_data;
    assign o_wr_en    = w_wr_en;
    assign o_busy     = w_busy;
    assign o_finished = r_finished;
    assign o_state    = r_state;

endmodule

`default_nettype wire
